// File: rtl/ro_sample_window.sv
// rtl/ro_sample_window.sv - windowed ring-oscillator sample accumulator feeding an absorption FIFO
// Build option: define RO_SAMPLE_SATURATE_EN to saturate FIFO words instead of wrapping them.
module ro_sample_window #(
    parameter int ADD_WIDTH  = 19,
    parameter int FIFO_WIDTH = 20,
    parameter int CNT_WIDTH  = 43,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic                  stop,
    input  logic [CNT_WIDTH-1:0]  num_samples,
    input  logic [CNT_WIDTH-1:0]  collect_cycles,
    input  logic                  sum_valid,
    input  logic [ADD_WIDTH-1:0]  sum,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [FIFO_WIDTH-1:0] fifo_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [15:0]           drop_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
`ifdef RO_SAMPLE_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] FIFO_MAX = ACC_WIDTH'({FIFO_WIDTH{1'b1}});
`endif

    state_t                 state;
    logic [CNT_WIDTH-1:0]   ns_lat;
    logic [CNT_WIDTH-1:0]   cc_lat;
    logic [CNT_WIDTH-1:0]   win_cnt;
    logic [CNT_WIDTH-1:0]   smp_cnt;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH:0]     acc_wide;
    logic [ACC_WIDTH-1:0]   sample;
    logic [CNT_WIDTH-1:0]   win_last_cnt;
    logic                   win_close;
    logic                   last_sample;
    logic [FIFO_WIDTH-1:0]  sample_fifo;

    always_comb begin
        acc_wide     = {1'b0, acc} + (ACC_WIDTH+1)'(sum_valid ? sum : '0);
        sample       = acc_wide[ACC_WIDTH] ? ACC_MAX : acc_wide[ACC_WIDTH-1:0];
        // A latched window length of 0 behaves as 1, so it closes every cycle.
        win_last_cnt = (cc_lat == '0) ? '0 : cc_lat - CNT_WIDTH'(1);
        win_close    = (win_cnt == win_last_cnt);
        last_sample  = ((smp_cnt + CNT_WIDTH'(1)) == ns_lat);
`ifdef RO_SAMPLE_SATURATE_EN
        sample_fifo  = (sample > FIFO_MAX) ? FIFO_MAX[FIFO_WIDTH-1:0] : sample[FIFO_WIDTH-1:0];
`else
        sample_fifo  = sample[FIFO_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ns_lat       <= '0;
            cc_lat       <= '0;
            win_cnt      <= '0;
            smp_cnt      <= '0;
            acc          <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            drop_count   <= '0;
        end else begin
            fifo_wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        ns_lat     <= num_samples;
                        cc_lat     <= collect_cycles;
                        acc        <= '0;
                        win_cnt    <= '0;
                        smp_cnt    <= '0;
                        overflow   <= 1'b0;
                        drop_count <= '0;
                        if (num_samples == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over a window closing in the same cycle.
                    if (stop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (win_close) begin
                        acc     <= '0;
                        win_cnt <= '0;
                        smp_cnt <= smp_cnt + CNT_WIDTH'(1);
                        if (fifo_full) begin
                            overflow <= 1'b1;
                            if (drop_count != 16'hFFFF)
                                drop_count <= drop_count + 16'd1;
                        end else begin
                            fifo_wr_en   <= 1'b1;
                            fifo_wr_data <= sample_fifo;
                        end
                        if (last_sample) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        acc     <= sample;
                        win_cnt <= win_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
